dout_display_driver: RTL

Downstream consumer of the CPU's Dout/Dval outputs for the RPN calculator board. When Dval is high, it captures the 8-bit result and interprets it as unsigned or two's-complement according to a mode bit. It converts the value to BCD with a sequential double-dabble engine. It then drives a 4-digit multiplexed 7-segment display: sign, hundreds, tens, ones.

---
 rtl/dout_display_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dout_display_driver.sv
// Captures CPU result bytes, converts them to BCD with a sequential double-dabble
// engine and scans sign/hundreds/tens/ones onto a multiplexed active-low 7-segment display.
module dout_display_driver #(
   parameter int REFRESH_DIV = 50_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] din,
   input  logic       dval,
   input  logic       signed_mode,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       busy,
   output logic       value_valid
);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t     state;
   logic       pair_valid;
   logic       held_mode;
   logic [7:0] held_val;
   logic       neg;
   logic [7:0] mag;
   logic [7:0] sh;
   logic [11:0] bcd;
   logic [2:0] cnt;
   logic [6:0] digits [4];
   logic [DIV_W-1:0] div;
   logic [1:0] scan_idx;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble step: correct every BCD nibble >= 5, then shift left.
   function automatic logic [19:0] dd_step(input logic [19:0] x);
      logic [19:0] y;
      y = x;
      for (int i = 0; i < 3; i++) begin
         if (y[8+4*i +: 4] >= 4'd5) y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
      end
      dd_step = y << 1;
   endfunction

   // Only 8 bits are needed: the largest magnitude (255 unsigned, 128 signed) fits.
   assign mag = (held_mode & held_val[7]) ? (~held_val + 8'd1) : held_val;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         pair_valid  <= 1'b0;
         held_mode   <= 1'b0;
         held_val    <= 8'h00;
         neg         <= 1'b0;
         sh          <= 8'h00;
         bcd         <= 12'h000;
         cnt         <= 3'd0;
         busy        <= 1'b0;
         value_valid <= 1'b0;
         // NOTE: the four digit registers are a tiny array, so they are reset like
         // any other flop; that is what keeps a stale value from reappearing.
         for (int i = 0; i < 4; i++) digits[i] <= SEG_BLANK;
      end else begin
         case (state)
            S_IDLE: begin
               if (dval) begin
                  if (!pair_valid || ({signed_mode, din} != {held_mode, held_val})) begin
                     held_mode  <= signed_mode;
                     held_val   <= din;
                     pair_valid <= 1'b1;
                     busy       <= 1'b1;
                     state      <= S_LOAD;
                  end
               end else begin
                  value_valid <= 1'b0;
                  pair_valid  <= 1'b0;
                  for (int i = 0; i < 4; i++) digits[i] <= SEG_BLANK;
               end
            end
            S_LOAD: begin
               neg   <= held_mode & held_val[7];
               sh    <= mag;
               bcd   <= 12'h000;
               cnt   <= 3'd0;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               {bcd, sh} <= dd_step({bcd, sh});
               cnt       <= cnt + 3'd1;
               if (cnt == 3'd7) state <= S_DONE;
            end
            S_DONE: begin
               digits[3]   <= neg ? SEG_DASH : SEG_BLANK;
               digits[2]   <= (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcd[11:8]);
               digits[1]   <= ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) ? SEG_BLANK
                                                                            : seg_code(bcd[7:4]);
               digits[0]   <= seg_code(bcd[3:0]);
               value_valid <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Scan runs free of the FSM; seg and an load on the same edge so they always agree.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div      <= '0;
         scan_idx <= 2'd0;
         seg      <= SEG_BLANK;
         an       <= 4'b1111;
         dp       <= 1'b1;
      end else begin
         if (div == DIV_W'(REFRESH_DIV - 1)) begin
            div      <= '0;
            scan_idx <= scan_idx + 2'd1;
         end else begin
            div <= div + DIV_W'(1);
         end
         seg <= digits[scan_idx];
         an  <= ~(4'b0001 << scan_idx);
         dp  <= 1'b1;
      end
   end

endmodule
